// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit: multi-cycle mult/multu/div/divu with HI/LO
// registers, mfhi/mflo reads and mthi/mtlo writes.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  output logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDU_out
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_a, r_b, r_hi, r_lo;
  logic [3:0]         r_op;
  logic               w_md_op, w_done, w_mt_ok;
  logic signed [63:0] w_smul;
  logic [63:0]        w_umul, w_sdiv, w_udiv;

  // Sign-magnitude division: avoids relying on the native signed divide for
  // 0x80000000 / -1, whose quotient simply wraps back to 0x80000000.
  // Returns {remainder, quotient}; remainder carries the dividend's sign.
  function automatic logic [63:0] sdiv(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb, q, r;
    ma = a[31] ? (32'd0 - a) : a;
    mb = b[31] ? (32'd0 - b) : b;
    q  = ma / mb;
    r  = ma % mb;
    if (a[31] ^ b[31]) q = 32'd0 - q;
    if (a[31])         r = 32'd0 - r;
    return {r, q};
  endfunction

  assign w_md_op = (MDUop >= 4'd1) && (MDUop <= 4'd4);
  assign w_mt_ok = (r_state == IDLE) && !req;
  assign w_done  = (r_state == RUN) && (r_cnt == CNT_W'(1));

  // Results depend only on the operands latched at issue.
  assign w_smul = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
  assign w_umul = {32'd0, r_a} * {32'd0, r_b};
  assign w_sdiv = sdiv(r_a, r_b);
  assign w_udiv = {r_a % r_b, r_a / r_b};

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start)  w_next = RUN;
      RUN:     if (w_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    start   = w_md_op && (r_state == IDLE) && !req;
    busy    = (r_state == RUN);
    MDU_out = 32'd0;
    if (MDUop == 4'd5)      MDU_out = r_hi;
    else if (MDUop == 4'd6) MDU_out = r_lo;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_a   <= '0;
      r_b   <= '0;
      r_op  <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else if (start) begin
      r_a   <= A;
      r_b   <= B;
      r_op  <= MDUop;
      r_cnt <= (MDUop <= 4'd2) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
    end else if (w_done) begin
      r_cnt <= '0;
      case (r_op)
        4'd1: {r_hi, r_lo} <= w_smul;
        4'd2: {r_hi, r_lo} <= w_umul;
        4'd3: if (r_b != 32'd0) {r_hi, r_lo} <= w_sdiv;
        4'd4: if (r_b != 32'd0) {r_hi, r_lo} <= w_udiv;
        default: ;
      endcase
    end else if (r_state == RUN) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end else if (w_mt_ok && MDUop == 4'd7) begin
      r_hi <= A;
    end else if (w_mt_ok && MDUop == 4'd8) begin
      r_lo <= A;
    end
  end

  assign HI = r_hi;
  assign LO = r_lo;

endmodule
